// File: rtl/match_event_counter.sv
// match_event_counter: synchronise and glitch-filter a raw match level, count its qualified rising edges
//   clk, rst     : clock, synchronous active-high reset
//   ena          : clock enable; when low, all state holds and event_pulse is 0
//   match_in     : raw asynchronous match level
//   clear        : synchronous clear of event_count and overflow
//   match_q      : filtered match level
//   event_pulse  : one-cycle strobe per qualified 0->1 transition
//   event_count  : saturating or wrapping event count
//   overflow     : sticky flag for an event arriving at all-ones
module match_event_counter #(
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_WIDTH     = 8,
    parameter bit SATURATE      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 match_in,
    input  logic                 clear,
    output logic                 match_q,
    output logic                 event_pulse,
    output logic [CNT_WIDTH-1:0] event_count,
    output logic                 overflow
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, RISE, HIGH, FALL} state_t;
    state_t state, state_n;
    logic [FW-1:0] filt_cnt, filt_n;
    logic sync1, sync2, done, ev;
    assign done = int'(filt_cnt) + 1 == FILTER_CYCLES;
    // only a qualified rise out of the low side counts; FALL->HIGH is chatter
    assign ev = (state == IDLE || state == RISE) && state_n == HIGH;
    always_comb begin
        state_n = state;
        filt_n  = filt_cnt;
        case (state)
            IDLE: if (sync2) begin
                state_n = FILTER_CYCLES == 1 ? HIGH : RISE;
                filt_n  = FILTER_CYCLES == 1 ? '0 : FW'(1);
            end
            RISE: if (!sync2 || done) begin
                state_n = sync2 ? HIGH : IDLE;
                filt_n  = '0;
            end else filt_n = filt_cnt + 1'b1;
            HIGH: if (!sync2) begin
                state_n = FILTER_CYCLES == 1 ? IDLE : FALL;
                filt_n  = FILTER_CYCLES == 1 ? '0 : FW'(1);
            end
            FALL: if (sync2 || done) begin
                state_n = sync2 ? HIGH : IDLE;
                filt_n  = '0;
            end else filt_n = filt_cnt + 1'b1;
            default: begin
                state_n = IDLE;
                filt_n  = '0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            state       <= IDLE;
            filt_cnt    <= '0;
            match_q     <= 1'b0;
            event_pulse <= 1'b0;
            event_count <= '0;
            overflow    <= 1'b0;
        end else if (!ena) begin
            event_pulse <= 1'b0;
        end else begin
            sync1       <= match_in;
            sync2       <= sync1;
            state       <= state_n;
            filt_cnt    <= filt_n;
            match_q     <= state_n == HIGH || state_n == FALL;
            event_pulse <= ev;
            if (ev && clear) begin
                event_count <= CNT_WIDTH'(1);
                overflow    <= 1'b0;
            end else if (ev) begin
                event_count <= &event_count ? (SATURATE ? event_count : '0) : event_count + 1'b1;
                if (&event_count) overflow <= 1'b1;
            end else if (clear) begin
                event_count <= '0;
                overflow    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_match_event_counter.sv
// tb_match_event_counter: directed checks of filtering, counting, clear, enable and reset behaviour
module tb_match_event_counter;
    logic clk = 1'b0, rst, ena, match_in, clear;
    logic mq0, ep0, ov0, mq1, ep1, ov1, mq2, ep2, ov2, mq3, ep3, ov3;
    logic [7:0] cnt0;
    logic [1:0] cnt1, cnt2;
    logic [2:0] cnt3;
    int nchk = 0, nerr = 0, pulses = 0;
    int exp_sat [5] = '{1, 2, 3, 3, 3};
    int exp_wrap[5] = '{1, 2, 3, 0, 1};

    always #5 clk = ~clk;
    always @(posedge clk) if (ep0) pulses <= pulses + 1;

    match_event_counter u0 (.clk(clk), .rst(rst), .ena(ena), .match_in(match_in), .clear(clear),
        .match_q(mq0), .event_pulse(ep0), .event_count(cnt0), .overflow(ov0));
    match_event_counter #(.CNT_WIDTH(2), .SATURATE(1)) u1 (.clk(clk), .rst(rst), .ena(ena),
        .match_in(match_in), .clear(clear), .match_q(mq1), .event_pulse(ep1), .event_count(cnt1), .overflow(ov1));
    match_event_counter #(.CNT_WIDTH(2), .SATURATE(0)) u2 (.clk(clk), .rst(rst), .ena(ena),
        .match_in(match_in), .clear(clear), .match_q(mq2), .event_pulse(ep2), .event_count(cnt2), .overflow(ov2));
    match_event_counter #(.CNT_WIDTH(3), .SATURATE(1)) u3 (.clk(clk), .rst(rst), .ena(ena),
        .match_in(match_in), .clear(clear), .match_q(mq3), .event_pulse(ep3), .event_count(cnt3), .overflow(ov3));

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic m, input int n);
        match_in = m;
        step(n);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; clear = 1'b0; match_in = 1'b1;
        step(2);
        chk("rst_mq", mq0, 0);
        chk("rst_pulse", ep0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_ovf", ov0, 0);
        rst = 1'b0;
        step(5);
        chk("rise_early", mq0, 0);
        step(1);
        chk("rise_mq", mq0, 1);
        chk("rise_pulse", ep0, 1);
        chk("rise_cnt", cnt0, 1);
        step(1);
        chk("pulse_one_cycle", ep0, 0);
        drive(1'b0, 12);
        chk("fall_mq", mq0, 0);
        chk("fall_pulses", pulses, 1);

        drive(1'b1, 3); drive(1'b0, 10); drive(1'b1, 3); drive(1'b0, 10);
        chk("glitch_mq", mq0, 0);
        chk("glitch_cnt", cnt0, 1);
        chk("glitch_pulses", pulses, 1);
        drive(1'b1, 4); drive(1'b0, 12);
        chk("min_pulse_cnt", cnt0, 2);
        chk("min_pulse_pulses", pulses, 2);

        drive(1'b1, 8);
        repeat (3) begin drive(1'b0, 2); drive(1'b1, 2); end
        chk("chatter_mq_hold", mq0, 1);
        drive(1'b0, 10);
        chk("chatter_mq_fall", mq0, 0);
        chk("chatter_cnt", cnt0, 3);
        chk("chatter_pulses", pulses, 3);

        drive(1'b1, 4);
        ena = 1'b0;
        step(10);
        chk("freeze_mq", mq0, 0);
        chk("freeze_pulse", ep0, 0);
        chk("freeze_cnt", cnt0, 3);
        ena = 1'b1;
        step(1);
        chk("resume_early", mq0, 0);
        step(1);
        chk("resume_mq", mq0, 1);
        chk("resume_pulse", ep0, 1);
        chk("resume_cnt", cnt0, 4);
        drive(1'b0, 12);

        rst = 1'b1;
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 6);
            chk("sat_pulse", ep1, 1);
            if (i < 5) begin
                chk("sat_cnt", cnt1, exp_sat[i]);
                chk("sat_ovf", ov1, i >= 3);
                chk("wrap_cnt", cnt2, exp_wrap[i]);
                chk("wrap_ovf", ov2, i >= 3);
            end
            if (i == 6) begin
                chk("w3_full_cnt", cnt3, 7);
                chk("w3_full_ovf", ov3, 0);
            end
            drive(1'b0, 8);
        end
        chk("w3_sat_cnt", cnt3, 7);
        chk("w3_sat_ovf", ov3, 1);

        drive(1'b1, 5);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("collide_cnt", cnt3, 1);
        chk("collide_ovf", ov3, 0);
        chk("collide_cnt_w8", cnt0, 1);
        chk("collide_pulse", ep0, 1);
        step(1);
        chk("collide_hold", cnt3, 1);
        ena = 1'b0; clear = 1'b1;
        step(1);
        chk("clear_ignored", cnt1, 1);
        ena = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clear_cnt", cnt1, 0);
        chk("clear_cnt_w3", cnt3, 0);
        chk("clear_ovf_w3", ov3, 0);
        chk("clear_keeps_mq", mq0, 1);

        drive(1'b0, 8);
        drive(1'b1, 4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(5);
        chk("rst_discard_early", mq0, 0);
        step(1);
        chk("rst_discard_mq", mq0, 1);
        chk("rst_discard_cnt", cnt0, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
